// File: rtl/prog_loader.sv
// Writer side of the 16x8 CPU instruction store: loads a framed byte stream
// (header, N bytes, XOR checksum) and releases the CPU once the frame verifies.
module prog_loader #(
  parameter int         DEPTH   = 16,
  parameter int         AW      = 4,
  parameter int         DW      = 8,
  parameter logic [3:0] MAGIC   = 4'hA,
  parameter int         TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_req_i,
  input  logic          in_valid_i,
  input  logic [DW-1:0] in_data_i,
  output logic          in_ready_o,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic [1:0]    err_code_o,
  output logic [AW:0]   word_count_o,
  output logic          cpu_run_o
);

  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  localparam logic [1:0] EC_NONE  = 2'b00;
  localparam logic [1:0] EC_MAGIC = 2'b01;
  localparam logic [1:0] EC_CSUM  = 2'b10;
  localparam logic [1:0] EC_TIME  = 2'b11;

  typedef enum logic [2:0] {IDLE, HDR, DATA, CSUM, DONE, ERR} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   mem_q [DEPTH];
  logic [DW-1:0]   csum_q, csum_d;
  logic [CW-1:0]   len_q, len_d;
  logic [CW-1:0]   wc_q, wc_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [1:0]      ecode_q, ecode_d;
  logic            busy, accept, we;
  logic [CW-1:0]   wc_inc;

  assign busy   = (state_q == HDR) || (state_q == DATA) || (state_q == CSUM);
  assign accept = in_valid_i && busy;
  assign wc_inc = wc_q + CW'(1);

  always_comb begin
    state_d = state_q;
    csum_d  = csum_q;
    len_d   = len_q;
    wc_d    = wc_q;
    timer_d = timer_q;
    ecode_d = ecode_q;
    we      = 1'b0;
    if (load_req_i) begin
      // Restart wins over any byte presented in the same cycle.
      state_d = HDR;
      csum_d  = '0;
      wc_d    = '0;
      timer_d = '0;
      ecode_d = EC_NONE;
    end else if (busy) begin
      if (accept) begin
        timer_d = '0;
        unique case (state_q)
          HDR: begin
            if (in_data_i[DW-1:DW-4] != MAGIC) begin
              state_d = ERR;
              ecode_d = EC_MAGIC;
            end else begin
              len_d   = {1'b0, in_data_i[AW-1:0]} + CW'(1);
              csum_d  = in_data_i;
              state_d = DATA;
            end
          end
          DATA: begin
            we     = 1'b1;
            csum_d = csum_q ^ in_data_i;
            wc_d   = wc_inc;
            if (wc_inc == len_q) state_d = CSUM;
          end
          default: begin
            if (in_data_i == csum_q) begin
              state_d = DONE;
            end else begin
              state_d = ERR;
              ecode_d = EC_CSUM;
            end
          end
        endcase
      end else if (timer_q == TLAST) begin
        // The idle cycle that would bring the timer to TIMEOUT aborts the load.
        state_d = ERR;
        ecode_d = EC_TIME;
        timer_d = '0;
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end else begin
      timer_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      csum_q  <= '0;
      len_q   <= '0;
      wc_q    <= '0;
      timer_q <= '0;
      ecode_q <= EC_NONE;
    end else begin
      state_q <= state_d;
      csum_q  <= csum_d;
      len_q   <= len_d;
      wc_q    <= wc_d;
      timer_q <= timer_d;
      ecode_q <= ecode_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[wc_q[AW-1:0]] <= in_data_i;
    end
  end

  assign rd_data_o    = mem_q[rd_addr_i];
  assign in_ready_o   = busy;
  assign busy_o       = busy;
  assign done_o       = (state_q == DONE);
  assign err_o        = (state_q == ERR);
  assign cpu_run_o    = (state_q == DONE);
  assign err_code_o   = ecode_q;
  assign word_count_o = wc_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a vector table for the short frames plus
// hand sequences for full depth, timeout, restart and asynchronous reset.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_req, in_valid;
  logic [7:0] in_data;
  logic [3:0] rd_addr;
  logic       in_ready, busy, done, err, cpu_run;
  logic [1:0] err_code;
  logic [4:0] word_count;
  logic [7:0] rd_data;

  int checks = 0;
  int errors = 0;

  prog_loader dut (
    .clk(clk), .rst_n(rst_n), .load_req_i(load_req), .in_valid_i(in_valid),
    .in_data_i(in_data), .in_ready_o(in_ready), .rd_addr_i(rd_addr),
    .rd_data_o(rd_data), .busy_o(busy), .done_o(done), .err_o(err),
    .err_code_o(err_code), .word_count_o(word_count), .cpu_run_o(cpu_run)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ld, vld;
    logic [7:0] d;
    logic [3:0] ra;
    logic       rdy, bsy, dn, er;
    logic [1:0] ec;
    logic [4:0] wc;
    logic [7:0] rd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic ld, logic vld, logic [7:0] d, logic [3:0] ra,
                              logic rdy, logic bsy, logic dn, logic er,
                              logic [1:0] ec, logic [4:0] wc, logic [7:0] rd);
    vec_t v;
    v.ld = ld; v.vld = vld; v.d = d; v.ra = ra;
    v.rdy = rdy; v.bsy = bsy; v.dn = dn; v.er = er;
    v.ec = ec; v.wc = wc; v.rd = rd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic ld, input logic vld, input logic [7:0] d);
    load_req = ld;
    in_valid = vld;
    in_data  = d;
    @(posedge clk);
    #1;
    load_req = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic check_mem(input string name, input logic [3:0] a, input logic [7:0] exp);
    rd_addr = a;
    #1;
    check($sformatf("%s[%0d]", name, a), 32'(rd_data), 32'(exp));
  endtask

  initial begin
    rst_n = 1'b0; load_req = 1'b0; in_valid = 1'b0; in_data = 8'h00; rd_addr = 4'h0;

    // Good frame A2 51 23 F0 csum 20, then bad magic, then bad checksum.
    vecs.push_back(mk(1, 0, 8'h00, 0, 1, 1, 0, 0, 2'b00, 0, 8'h00));
    vecs.push_back(mk(0, 1, 8'hA2, 0, 1, 1, 0, 0, 2'b00, 0, 8'h00));
    vecs.push_back(mk(0, 1, 8'h51, 0, 1, 1, 0, 0, 2'b00, 1, 8'h51));
    vecs.push_back(mk(0, 1, 8'h23, 1, 1, 1, 0, 0, 2'b00, 2, 8'h23));
    vecs.push_back(mk(0, 0, 8'h00, 2, 1, 1, 0, 0, 2'b00, 2, 8'h00));
    vecs.push_back(mk(0, 1, 8'hF0, 2, 1, 1, 0, 0, 2'b00, 3, 8'hF0));
    vecs.push_back(mk(0, 1, 8'h20, 0, 0, 0, 1, 0, 2'b00, 3, 8'h51));
    vecs.push_back(mk(0, 1, 8'h77, 1, 0, 0, 1, 0, 2'b00, 3, 8'h23));
    vecs.push_back(mk(0, 0, 8'h00, 3, 0, 0, 1, 0, 2'b00, 3, 8'h00));
    vecs.push_back(mk(1, 0, 8'h00, 0, 1, 1, 0, 0, 2'b00, 0, 8'h51));
    vecs.push_back(mk(0, 1, 8'h52, 1, 0, 0, 0, 1, 2'b01, 0, 8'h23));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 1, 2'b01, 0, 8'h51));
    vecs.push_back(mk(1, 0, 8'h00, 0, 1, 1, 0, 0, 2'b00, 0, 8'h51));
    vecs.push_back(mk(0, 1, 8'hA0, 0, 1, 1, 0, 0, 2'b00, 0, 8'h51));
    vecs.push_back(mk(0, 1, 8'h7F, 0, 1, 1, 0, 0, 2'b00, 1, 8'h7F));
    vecs.push_back(mk(0, 1, 8'h00, 1, 0, 0, 0, 1, 2'b10, 1, 8'h23));
    vecs.push_back(mk(0, 1, 8'h55, 0, 0, 0, 0, 1, 2'b10, 1, 8'h7F));

    repeat (3) @(posedge clk);
    #1;
    check("rst.ready", 32'(in_ready), 0);
    check("rst.busy", 32'(busy), 0);
    check("rst.done", 32'(done), 0);
    check("rst.err", 32'(err), 0);
    check("rst.ecode", 32'(err_code), 0);
    check("rst.wc", 32'(word_count), 0);
    check("rst.run", 32'(cpu_run), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle.busy", 32'(busy), 0);

    for (int i = 0; i < vecs.size(); i++) begin
      rd_addr = vecs[i].ra;
      cyc(vecs[i].ld, vecs[i].vld, vecs[i].d);
      check($sformatf("v%0d.ready", i), 32'(in_ready), 32'(vecs[i].rdy));
      check($sformatf("v%0d.busy", i), 32'(busy), 32'(vecs[i].bsy));
      check($sformatf("v%0d.done", i), 32'(done), 32'(vecs[i].dn));
      check($sformatf("v%0d.err", i), 32'(err), 32'(vecs[i].er));
      check($sformatf("v%0d.ecode", i), 32'(err_code), 32'(vecs[i].ec));
      check($sformatf("v%0d.wc", i), 32'(word_count), 32'(vecs[i].wc));
      check($sformatf("v%0d.run", i), 32'(cpu_run), 32'(vecs[i].dn));
      check($sformatf("v%0d.rd", i), 32'(rd_data), 32'(vecs[i].rd));
    end

    // Full depth with a stall cycle before every data byte.
    cyc(1, 0, 8'h00);
    cyc(0, 1, 8'hAF);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 8'hEE);
      cyc(0, 1, 8'(i));
      if (i == 14) check("full.busy15", 32'(busy), 1);
    end
    check("full.wc16", 32'(word_count), 16);
    check("full.incsum", 32'(in_ready), 1);
    cyc(0, 1, 8'hAF);
    check("full.done", 32'(done), 1);
    check("full.run", 32'(cpu_run), 1);
    check("full.err", 32'(err), 0);
    check("full.wc", 32'(word_count), 16);
    for (int i = 0; i < 16; i++) check_mem("full.mem", 4'(i), 8'(i));

    // Timeout: 254 idle cycles are tolerated, the 255th aborts.
    cyc(1, 0, 8'h00);
    cyc(0, 1, 8'hA1);
    repeat (254) cyc(0, 0, 8'h00);
    check("to254.busy", 32'(busy), 1);
    check("to254.err", 32'(err), 0);
    cyc(0, 0, 8'h00);
    check("to255.err", 32'(err), 1);
    check("to255.ecode", 32'(err_code), 3);
    check("to255.busy", 32'(busy), 0);
    check("to255.run", 32'(cpu_run), 0);
    check_mem("to.mem", 4'h0, 8'h00);

    // Restart mid-DATA: the byte offered with load_req must not land.
    cyc(1, 0, 8'h00);
    cyc(0, 1, 8'hA3);
    cyc(0, 1, 8'h11);
    cyc(0, 1, 8'h22);
    check("rs.wc2", 32'(word_count), 2);
    cyc(1, 1, 8'h33);
    check("rs.busy", 32'(busy), 1);
    check("rs.wc", 32'(word_count), 0);
    check("rs.ready", 32'(in_ready), 1);
    check_mem("rs.nowr", 4'h2, 8'h02);
    cyc(0, 1, 8'hA0);
    cyc(0, 1, 8'h99);
    check("rs.wc1", 32'(word_count), 1);
    cyc(0, 1, 8'h39);
    check("rs.done", 32'(done), 1);
    check_mem("rs.mem", 4'h0, 8'h99);
    check_mem("rs.mem", 4'h1, 8'h22);
    check_mem("rs.mem", 4'h2, 8'h02);
    check_mem("rs.mem", 4'h3, 8'h03);

    // Asynchronous reset mid-load clears everything including memory.
    cyc(1, 0, 8'h00);
    cyc(0, 1, 8'hA5);
    cyc(0, 1, 8'h77);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar.busy", 32'(busy), 0);
    check("ar.ready", 32'(in_ready), 0);
    check("ar.wc", 32'(word_count), 0);
    check("ar.done", 32'(done), 0);
    check("ar.err", 32'(err), 0);
    check("ar.ecode", 32'(err_code), 0);
    for (int i = 0; i < 16; i++) check_mem("ar.mem", 4'(i), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 1, 8'hA0);
    check("ar.idle", 32'(busy), 0);
    check("ar.wc0", 32'(word_count), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
Writer side of the 16x8 instruction store that the accumulator CPU fetches from. Accepts a framed byte stream on a valid/ready interface: header, N instruction bytes, XOR checksum. Writes the bytes into an internal 16-entry memory and exposes a combinational read port for the CPU fetch path. Holds the CPU in a stopped state (cpu_run low) until a frame has been loaded and verified.

Parameters:
DEPTH, 16, number of instruction words (fixed at 16; AW derived)
AW, 4, address width
DW, 8, instruction/byte width
MAGIC, 4'hA, required upper nibble of the header byte
TIMEOUT, 255, max idle cycles between accepted bytes while loading

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
load_req  input  1  start (or restart) a load; level sampled each cycle
in_valid  input  1  in_data valid
in_data  input  8  stream byte
in_ready  output  1  loader can accept a byte this cycle
rd_addr  input  4  CPU fetch address
rd_data  output  8  mem[rd_addr], combinational
busy  output  1  load in progress (HDR/DATA/CSUM)
done  output  1  last frame verified OK
err  output  1  last frame failed
err_code  output  2  01 bad magic, 10 checksum mismatch, 11 timeout, 00 none
word_count  output  5  bytes written in current/last frame (0..16)
cpu_run  output  1  CPU may execute; equals done

Behaviour:
- Reset (async): state IDLE; all 16 memory words 8'h00; in_ready=0, busy=0, done=0, err=0, err_code=00, word_count=0, cpu_run=0, internal checksum=0, length=0, timer=0.
- Accept: in_valid && in_ready at a rising edge. in_ready=1 exactly in HDR, DATA, CSUM (Moore, no in_valid dependency).
- States: IDLE, HDR, DATA, CSUM, DONE, ERR.
- IDLE/DONE/ERR + load_req=1 -> HDR next cycle; clears done, err, err_code, word_count, checksum, timer. Memory not cleared; words beyond N keep prior contents.
- HDR accept: if in_data[7:4]!=MAGIC -> ERR, err_code=01. Else length=in_data[3:0]+1 (1..16), checksum=in_data -> DATA.
- DATA accept: mem[word_count]<=in_data; checksum^=in_data; word_count++. rd_data shows the new value from the next cycle. When the incremented word_count equals length -> CSUM.
- CSUM accept: if in_data==checksum -> DONE (done=1, cpu_run=1); else ERR, err_code=10.
- Timer: in HDR/DATA/CSUM, resets to 0 on each accept, else increments. When timer reaches TIMEOUT without accept -> ERR, err_code=11 on the next edge. Timer held at 0 in other states.
- load_req=1 while busy: abort and restart at HDR; a byte presented in that same cycle is not accepted (load_req has priority; in_ready remains 1 but the transfer is discarded). Bench must not count it.
- busy=1 in HDR/DATA/CSUM. done and err are mutually exclusive and hold until the next load_req or reset.
- Reset mid-load: immediate return to reset values, memory cleared.
- rd_data = mem[rd_addr] with no latency and no dependence on state. The CPU gates its own PC on cpu_run.
- word_count: 5-bit, never exceeds 16; not cleared on DONE/ERR.

Test Plan:
- Good frame: load_req pulse; bytes A2,51,23,F0,20 -> done=1, cpu_run=1, err=0, word_count=3, mem[0..2]=51,23,F0, rd_addr=1 gives 23.
- Bad magic: header 52 -> ERR next edge, err_code=01, word_count=0, memory unchanged, cpu_run=0.
- Bad checksum: A0,7F, csum 00 (expected DF) -> err=1, err_code=10, mem[0]=7F retained.
- Full depth + backpressure: header AF, 16 bytes 00..0F with in_valid toggled every other cycle, csum = AF^(XOR 00..0F)=AF -> done=1, word_count=16, mem[i]=i.
- Timeout: header A1, then in_valid low for 255 cycles -> err_code=11, busy=0; no error at 254 cycles.
- Restart and reset: load_req asserted mid-DATA -> state HDR, word_count=0, byte that cycle ignored. Then rst_n low mid-load -> all outputs zero, rd_data=00 at every address.
